// File: rtl/ld_project.sv
// Appliance control register file: two fridges, two ACs, two washers with phase countdown.
// Optional AC setpoint saturation to 16..30 is enabled by defining AC_TEMP_CLAMP_EN.
module ld_project (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    input  logic       s4,
    input  logic       s5,
    input  logic [4:0] inp,
    input  logic [4:0] wash,
    input  logic [4:0] rinse,
    input  logic [4:0] spin,
    input  logic [4:0] cloth,
    output logic [4:0] fgt1,
    output logic [4:0] fgt2,
    output logic [4:0] frt1,
    output logic [4:0] frt2,
    output logic [4:0] fgc1,
    output logic [4:0] fgc2,
    output logic [4:0] frc1,
    output logic [4:0] frc2,
    output logic       ice1,
    output logic       ice2,
    output logic [4:0] actemp1,
    output logic [4:0] actemp2,
    output logic [4:0] accap1,
    output logic [4:0] accap2,
    output logic [4:0] acfan1,
    output logic [4:0] acfan2,
    output logic [4:0] actimer1,
    output logic [4:0] actimer2,
    output logic [4:0] wash_out_1,
    output logic [4:0] wash_out_2,
    output logic [4:0] rinse_out_1,
    output logic [4:0] rinse_out_2,
    output logic [4:0] spin_out_1,
    output logic [4:0] spin_out_2,
    output logic [4:0] cloth_out_1,
    output logic [4:0] cloth_out_2
);

    localparam int unsigned DW = 5;
    localparam int unsigned NU = 2;

    localparam logic [1:0] CLS_FRIDGE = 2'b00;
    localparam logic [1:0] CLS_AC     = 2'b01;
    localparam logic [1:0] CLS_WASHER = 2'b10;

    logic [DW-1:0] r_fgt     [NU];
    logic [DW-1:0] r_frt     [NU];
    logic [DW-1:0] r_fgc     [NU];
    logic [DW-1:0] r_frc     [NU];
    logic          r_ice     [NU];
    logic [DW-1:0] r_actemp  [NU];
    logic [DW-1:0] r_accap   [NU];
    logic [DW-1:0] r_acfan   [NU];
    logic [DW-1:0] r_actimer [NU];
    logic [DW-1:0] r_wash    [NU];
    logic [DW-1:0] r_rinse   [NU];
    logic [DW-1:0] r_spin    [NU];
    logic [DW-1:0] r_cloth   [NU];
    logic          r_run     [NU];

    logic [DW-1:0] w_wash_nxt  [NU];
    logic [DW-1:0] w_rinse_nxt [NU];
    logic [DW-1:0] w_spin_nxt  [NU];
    logic [DW-1:0] w_cloth_nxt [NU];
    logic          w_run_nxt   [NU];

    logic [1:0]    w_cls;
    logic [1:0]    w_sel;
    logic [1:0]    w_cmd;
    logic [DW-1:0] w_actemp_in;

    assign w_cls = {s0, s1};
    assign w_sel = {s3, s4};
    assign w_cmd = {s4, s5};

`ifdef AC_TEMP_CLAMP_EN
    assign w_actemp_in = (inp < DW'(16)) ? DW'(16) :
                         (inp > DW'(30)) ? DW'(30) : inp;
`else
    assign w_actemp_in = inp;
`endif

    // Fridge and AC settings: plain captures into the addressed unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < NU; u++) begin
                r_fgt[u]     <= DW'(4);
                r_frt[u]     <= '0;
                r_fgc[u]     <= '0;
                r_frc[u]     <= '0;
                r_ice[u]     <= 1'b0;
                r_actemp[u]  <= DW'(24);
                r_accap[u]   <= '0;
                r_acfan[u]   <= '0;
                r_actimer[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NU; u++) begin
                if (w_cls == CLS_FRIDGE && s2 == 1'(u)) begin
                    case (w_sel)
                        2'b00: if (s5) r_frt[u] <= inp; else r_fgt[u] <= inp;
                        2'b01: if (s5) r_frc[u] <= {3'b000, inp[1:0]};
                               else    r_fgc[u] <= {3'b000, inp[1:0]};
                        2'b10: r_ice[u] <= inp[0];
                        default: ;
                    endcase
                end
                if (w_cls == CLS_AC && s2 == 1'(u)) begin
                    case (w_sel)
                        2'b00:   r_actemp[u]  <= w_actemp_in;
                        2'b01:   r_accap[u]   <= {3'b000, inp[1:0]};
                        2'b10:   r_acfan[u]   <= {2'b00, inp[2:0]};
                        default: r_actimer[u] <= {2'b00, inp[2:0]};
                    endcase
                end
            end
        end
    end

    // Washer next state: an addressed command wins over the running countdown.
    always_comb begin
        for (int u = 0; u < NU; u++) begin
            w_wash_nxt[u]  = r_wash[u];
            w_rinse_nxt[u] = r_rinse[u];
            w_spin_nxt[u]  = r_spin[u];
            w_cloth_nxt[u] = r_cloth[u];
            w_run_nxt[u]   = r_run[u];
            if (w_cls == CLS_WASHER && s2 == 1'(u)) begin
                if (!s3) begin
                    w_wash_nxt[u]  = wash;
                    w_rinse_nxt[u] = rinse;
                    w_spin_nxt[u]  = spin;
                    w_cloth_nxt[u] = cloth;
                    w_run_nxt[u]   = 1'b0;
                end else begin
                    case (w_cmd)
                        2'b00: begin
                            if (r_wash[u] == '0 && r_rinse[u] == '0 && r_spin[u] == '0) begin
                                w_cloth_nxt[u] = '0;
                                w_run_nxt[u]   = 1'b0;
                            end else begin
                                w_run_nxt[u]   = 1'b1;
                            end
                        end
                        2'b01: w_run_nxt[u] = 1'b0;
                        2'b10: begin
                            if (r_wash[u] != '0)       w_wash_nxt[u]  = '0;
                            else if (r_rinse[u] != '0) w_rinse_nxt[u] = '0;
                            else                       w_spin_nxt[u]  = '0;
                        end
                        default: begin
                            w_wash_nxt[u]  = '0;
                            w_rinse_nxt[u] = '0;
                            w_spin_nxt[u]  = '0;
                            w_cloth_nxt[u] = '0;
                            w_run_nxt[u]   = 1'b0;
                        end
                    endcase
                end
            end else if (r_run[u]) begin
                if (r_wash[u] != '0) begin
                    w_wash_nxt[u] = r_wash[u] - DW'(1);
                end else if (r_rinse[u] != '0) begin
                    w_rinse_nxt[u] = r_rinse[u] - DW'(1);
                end else if (r_spin[u] != '0) begin
                    w_spin_nxt[u] = r_spin[u] - DW'(1);
                    if (r_spin[u] == DW'(1)) begin
                        w_cloth_nxt[u] = '0;
                        w_run_nxt[u]   = 1'b0;
                    end
                end else begin
                    w_cloth_nxt[u] = '0;
                    w_run_nxt[u]   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < NU; u++) begin
                r_wash[u]  <= '0;
                r_rinse[u] <= '0;
                r_spin[u]  <= '0;
                r_cloth[u] <= '0;
                r_run[u]   <= 1'b0;
            end
        end else begin
            for (int u = 0; u < NU; u++) begin
                r_wash[u]  <= w_wash_nxt[u];
                r_rinse[u] <= w_rinse_nxt[u];
                r_spin[u]  <= w_spin_nxt[u];
                r_cloth[u] <= w_cloth_nxt[u];
                r_run[u]   <= w_run_nxt[u];
            end
        end
    end

    assign fgt1        = r_fgt[0];
    assign fgt2        = r_fgt[1];
    assign frt1        = r_frt[0];
    assign frt2        = r_frt[1];
    assign fgc1        = r_fgc[0];
    assign fgc2        = r_fgc[1];
    assign frc1        = r_frc[0];
    assign frc2        = r_frc[1];
    assign ice1        = r_ice[0];
    assign ice2        = r_ice[1];
    assign actemp1     = r_actemp[0];
    assign actemp2     = r_actemp[1];
    assign accap1      = r_accap[0];
    assign accap2      = r_accap[1];
    assign acfan1      = r_acfan[0];
    assign acfan2      = r_acfan[1];
    assign actimer1    = r_actimer[0];
    assign actimer2    = r_actimer[1];
    assign wash_out_1  = r_wash[0];
    assign wash_out_2  = r_wash[1];
    assign rinse_out_1 = r_rinse[0];
    assign rinse_out_2 = r_rinse[1];
    assign spin_out_1  = r_spin[0];
    assign spin_out_2  = r_spin[1];
    assign cloth_out_1 = r_cloth[0];
    assign cloth_out_2 = r_cloth[1];

endmodule

// File: tb/tb_ld_project.sv
// Directed self-checking bench for ld_project; expected values are hand-computed.
module tb_ld_project;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s0, s1, s2, s3, s4, s5;
    logic [4:0] inp, wash, rinse, spin, cloth;
    logic [4:0] fgt1, fgt2, frt1, frt2, fgc1, fgc2, frc1, frc2;
    logic       ice1, ice2;
    logic [4:0] actemp1, actemp2, accap1, accap2, acfan1, acfan2, actimer1, actimer2;
    logic [4:0] wash_out_1, wash_out_2, rinse_out_1, rinse_out_2;
    logic [4:0] spin_out_1, spin_out_2, cloth_out_1, cloth_out_2;

    int errors = 0;
    int checks = 0;

    ld_project dut (
        .clk(clk), .rst_n(rst_n),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
        .inp(inp), .wash(wash), .rinse(rinse), .spin(spin), .cloth(cloth),
        .fgt1(fgt1), .fgt2(fgt2), .frt1(frt1), .frt2(frt2),
        .fgc1(fgc1), .fgc2(fgc2), .frc1(frc1), .frc2(frc2),
        .ice1(ice1), .ice2(ice2),
        .actemp1(actemp1), .actemp2(actemp2), .accap1(accap1), .accap2(accap2),
        .acfan1(acfan1), .acfan2(acfan2), .actimer1(actimer1), .actimer2(actimer2),
        .wash_out_1(wash_out_1), .wash_out_2(wash_out_2),
        .rinse_out_1(rinse_out_1), .rinse_out_2(rinse_out_2),
        .spin_out_1(spin_out_1), .spin_out_2(spin_out_2),
        .cloth_out_1(cloth_out_1), .cloth_out_2(cloth_out_2)
    );

    always #5 clk = ~clk;

    // Selector bit order matches the s0..s5 strings used in the plan (s0 is the MSB).
    task automatic set_sel(input logic [5:0] s);
        {s0, s1, s2, s3, s4, s5} = s;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_sel(6'b111000);
        inp = '0; wash = '0; rinse = '0; spin = '0; cloth = '0;
        tick(2);
        checks++; if (fgt1 !== 5'd4)    begin errors++; $display("FAIL reset_fgt1: got %0d want 4", fgt1); end
        checks++; if (frt2 !== 5'd0)    begin errors++; $display("FAIL reset_frt2: got %0d want 0", frt2); end
        checks++; if (actemp2 !== 5'd24) begin errors++; $display("FAIL reset_actemp2: got %0d want 24", actemp2); end
        checks++; if ({wash_out_1, cloth_out_2, ice1} !== 11'd0)
            begin errors++; $display("FAIL reset_washer_ice: got %0h want 0", {wash_out_1, cloth_out_2, ice1}); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_fridge();
        set_sel(6'b000000); inp = 5'b10101; tick(1);
        checks++; if (fgt1 !== 5'b10101) begin errors++; $display("FAIL fridge_fgt1: got %b want 10101", fgt1); end
        set_sel(6'b000001); inp = 5'b11101; tick(1);
        checks++; if (frt1 !== 5'b11101) begin errors++; $display("FAIL fridge_frt1: got %b want 11101", frt1); end
        set_sel(6'b000010); inp = 5'b11111; tick(1);
        checks++; if (fgc1 !== 5'b00011) begin errors++; $display("FAIL fridge_fgc1: got %b want 00011", fgc1); end
        checks++; if ({fgt2, frt2, fgc2, frc1} !== {5'd4, 5'd0, 5'd0, 5'd0})
            begin errors++; $display("FAIL fridge2_hold: got %h want %h", {fgt2, frt2, fgc2, frc1}, {5'd4, 15'd0}); end
        set_sel(6'b001000); inp = 5'd7; tick(1);
        checks++; if ({fgt2, fgt1} !== {5'd7, 5'b10101})
            begin errors++; $display("FAIL fridge2_fgt: got %h want %h", {fgt2, fgt1}, {5'd7, 5'b10101}); end
    endtask

    task automatic test_ice();
        set_sel(6'b000100); inp = 5'b00001; tick(1);
        checks++; if (ice1 !== 1'b1) begin errors++; $display("FAIL ice_set: got %b want 1", ice1); end
        inp = 5'b00000; tick(1);
        checks++; if (ice1 !== 1'b0) begin errors++; $display("FAIL ice_clear: got %b want 0", ice1); end
        set_sel(6'b000110); inp = 5'b11111; tick(1);
        checks++; if ({fgt1, frt1, fgc1, frc1, ice1, ice2} !== {5'b10101, 5'b11101, 5'd3, 5'd0, 1'b0, 1'b0})
            begin errors++; $display("FAIL fridge_noop: got %h want %h",
                {fgt1, frt1, fgc1, frc1, ice1, ice2}, {5'b10101, 5'b11101, 5'd3, 5'd0, 2'b00}); end
    endtask

    task automatic test_ac();
        logic [4:0] exp_lo, exp_hi;
`ifdef AC_TEMP_CLAMP_EN
        exp_lo = 5'd16; exp_hi = 5'd30;
`else
        exp_lo = 5'd15; exp_hi = 5'd31;
`endif
        set_sel(6'b010000); inp = 5'b01111; tick(1);
        checks++; if (actemp1 !== exp_lo) begin errors++; $display("FAIL ac_temp_low: got %0d want %0d", actemp1, exp_lo); end
        inp = 5'b11111; tick(1);
        checks++; if (actemp1 !== exp_hi) begin errors++; $display("FAIL ac_temp_high: got %0d want %0d", actemp1, exp_hi); end
        set_sel(6'b010010); inp = 5'b11110; tick(1);
        checks++; if (accap1 !== 5'b00010) begin errors++; $display("FAIL ac_cap: got %b want 00010", accap1); end
        set_sel(6'b010100); inp = 5'b11110; tick(1);
        checks++; if (acfan1 !== 5'b00110) begin errors++; $display("FAIL ac_fan: got %b want 00110", acfan1); end
        set_sel(6'b010110); inp = 5'b11100; tick(1);
        checks++; if (actimer1 !== 5'b00100) begin errors++; $display("FAIL ac_timer: got %b want 00100", actimer1); end
        checks++; if ({actemp2, accap2, acfan2, actimer2} !== {5'd24, 15'd0})
            begin errors++; $display("FAIL ac2_hold: got %h want %h", {actemp2, accap2, acfan2, actimer2}, {5'd24, 15'd0}); end
    endtask

    task automatic test_wash_run();
        logic [19:0] exp;
        set_sel(6'b100000); wash = 5'd7; rinse = 5'd13; spin = 5'd12; cloth = 5'd2; tick(1);
        checks++; if ({wash_out_1, rinse_out_1, spin_out_1, cloth_out_1} !== {5'd7, 5'd13, 5'd12, 5'd2})
            begin errors++; $display("FAIL wash_load: got %h want %h",
                {wash_out_1, rinse_out_1, spin_out_1, cloth_out_1}, {5'd7, 5'd13, 5'd12, 5'd2}); end
        set_sel(6'b100100); tick(1);
        checks++; if (wash_out_1 !== 5'd7) begin errors++; $display("FAIL wash_start: got %0d want 7", wash_out_1); end
        set_sel(6'b111000);
        for (int t = 1; t <= 34; t++) begin
            tick(1);
            exp[19:15] = (t >= 7) ? 5'd0 : 5'(7 - t);
            exp[14:10] = (t <= 7) ? 5'd13 : (t >= 20) ? 5'd0 : 5'(20 - t);
            exp[9:5]   = (t <= 20) ? 5'd12 : (t >= 32) ? 5'd0 : 5'(32 - t);
            exp[4:0]   = (t >= 32) ? 5'd0 : 5'd2;
            checks++;
            if ({wash_out_1, rinse_out_1, spin_out_1, cloth_out_1} !== exp) begin
                errors++;
                $display("FAIL wash_count_t%0d: got %h want %h", t,
                    {wash_out_1, rinse_out_1, spin_out_1, cloth_out_1}, exp);
            end
        end
        checks++; if ({wash_out_2, rinse_out_2, spin_out_2, cloth_out_2} !== 20'd0)
            begin errors++; $display("FAIL wash2_idle: got %h want 0", {wash_out_2, rinse_out_2, spin_out_2, cloth_out_2}); end
    endtask

    task automatic test_wash_cmds();
        set_sel(6'b100000); wash = 5'd5; rinse = 5'd3; spin = 5'd4; cloth = 5'd1; tick(1);
        set_sel(6'b100100); tick(1);
        set_sel(6'b111000); tick(2);
        checks++; if (wash_out_1 !== 5'd3) begin errors++; $display("FAIL cmd_run2: got %0d want 3", wash_out_1); end
        set_sel(6'b100101); tick(1);
        set_sel(6'b111000); tick(3);
        checks++; if (wash_out_1 !== 5'd3) begin errors++; $display("FAIL cmd_pause: got %0d want 3", wash_out_1); end
        set_sel(6'b100100); tick(1);
        set_sel(6'b111000); tick(1);
        checks++; if (wash_out_1 !== 5'd2) begin errors++; $display("FAIL cmd_resume: got %0d want 2", wash_out_1); end
        set_sel(6'b100110); tick(1);
        checks++; if ({wash_out_1, rinse_out_1, spin_out_1, cloth_out_1} !== {5'd0, 5'd3, 5'd4, 5'd1})
            begin errors++; $display("FAIL cmd_skip: got %h want %h",
                {wash_out_1, rinse_out_1, spin_out_1, cloth_out_1}, {5'd0, 5'd3, 5'd4, 5'd1}); end
        set_sel(6'b111000); tick(1);
        checks++; if (rinse_out_1 !== 5'd2) begin errors++; $display("FAIL cmd_after_skip: got %0d want 2", rinse_out_1); end
        set_sel(6'b100111); tick(1);
        checks++; if ({wash_out_1, rinse_out_1, spin_out_1, cloth_out_1} !== 20'd0)
            begin errors++; $display("FAIL cmd_abort: got %h want 0", {wash_out_1, rinse_out_1, spin_out_1, cloth_out_1}); end
        set_sel(6'b111000); tick(2);
        checks++; if ({wash_out_1, rinse_out_1, spin_out_1, cloth_out_1} !== 20'd0)
            begin errors++; $display("FAIL cmd_abort_hold: got %h want 0", {wash_out_1, rinse_out_1, spin_out_1, cloth_out_1}); end
    endtask

    task automatic test_reset_mid_run();
        set_sel(6'b100000); wash = 5'd4; rinse = 5'd2; spin = 5'd2; cloth = 5'd3; tick(1);
        set_sel(6'b100100); tick(1);
        set_sel(6'b111000); tick(2);
        checks++; if (wash_out_1 !== 5'd2) begin errors++; $display("FAIL rst_pre: got %0d want 2", wash_out_1); end
        rst_n = 1'b0;
        #1;
        checks++; if ({wash_out_1, rinse_out_1, spin_out_1, cloth_out_1} !== 20'd0)
            begin errors++; $display("FAIL rst_async_washer: got %h want 0", {wash_out_1, rinse_out_1, spin_out_1, cloth_out_1}); end
        checks++; if ({fgt1, frt1, fgc1, actemp1, acfan1} !== {5'd4, 5'd0, 5'd0, 5'd24, 5'd0})
            begin errors++; $display("FAIL rst_async_regs: got %h want %h", {fgt1, frt1, fgc1, actemp1, acfan1}, {5'd4, 10'd0, 5'd24, 5'd0}); end
        #1;
        rst_n = 1'b1;
        set_sel(6'b100000); wash = 5'd6; rinse = 5'd0; spin = 5'd1; cloth = 5'd2; tick(1);
        set_sel(6'b111000); tick(3);
        checks++; if ({wash_out_1, spin_out_1, cloth_out_1} !== {5'd6, 5'd1, 5'd2})
            begin errors++; $display("FAIL rst_no_resume: got %h want %h", {wash_out_1, spin_out_1, cloth_out_1}, {5'd6, 5'd1, 5'd2}); end
    endtask

    initial begin
        test_reset();
        test_fridge();
        test_ice();
        test_ac();
        test_wash_run();
        test_wash_cmds();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
